// File: rtl/tex_env_sequencer.sv
// Multi-texture scheduler: runs each fragment through the enabled texture stages in
// ascending order on one shared, pipelined TexEnv combiner, chaining stage results.
module tex_env_sequencer #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int TMU_COUNT       = 2,
    parameter int TEXENV_LATENCY  = 2
) (
    input  logic                                   aclk,
    input  logic                                   reset,
    input  logic                                   cfg_we,
    input  logic [3:0]                             cfg_tmu,
    input  logic                                   cfg_enable,
    input  logic [2:0]                             cfg_func,
    input  logic [4*SUB_PIXEL_WIDTH-1:0]           cfg_env_color,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [4*SUB_PIXEL_WIDTH-1:0]           s_primary_color,
    input  logic [TMU_COUNT*4*SUB_PIXEL_WIDTH-1:0] s_tex_colors,
    output logic [2:0]                             te_func,
    output logic [4*SUB_PIXEL_WIDTH-1:0]           te_tex_src_color,
    output logic [4*SUB_PIXEL_WIDTH-1:0]           te_primary_color,
    output logic [4*SUB_PIXEL_WIDTH-1:0]           te_env_color,
    input  logic [4*SUB_PIXEL_WIDTH-1:0]           te_color,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [4*SUB_PIXEL_WIDTH-1:0]           m_color,
    output logic                                   busy,
    output logic [1:0]                             dbg_state
);
    localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;
    localparam int IW = (TMU_COUNT > 1) ? $clog2(TMU_COUNT) : 1;
    localparam int CW = (TEXENV_LATENCY > 1) ? $clog2(TEXENV_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(TEXENV_LATENCY - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // Both s_* and m_* ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid keeps its data stable until then.

    logic [1:0]             state;
    logic [TMU_COUNT-1:0]   stg_en;
    logic [2:0]             stg_func [TMU_COUNT];
    logic [PIXEL_WIDTH-1:0] stg_env  [TMU_COUNT];
    logic [TMU_COUNT-1:0]   pend;
    logic [2:0]             wrk_func [TMU_COUNT];
    logic [PIXEL_WIDTH-1:0] wrk_env  [TMU_COUNT];
    logic [PIXEL_WIDTH-1:0] wrk_tex  [TMU_COUNT];
    logic [PIXEL_WIDTH-1:0] tex_in   [TMU_COUNT];
    logic [IW-1:0]          cur_k;
    logic [IW-1:0]          first_k;
    logic [IW-1:0]          next_k;
    logic [CW-1:0]          cnt;
    logic                   cfg_ok;
    logic [IW-1:0]          cfg_idx;
    logic [2:0]             cfg_func_clean;

    function automatic logic [IW-1:0] lowest(input logic [TMU_COUNT-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = TMU_COUNT - 1; i >= 0; i--) begin
            if (m[i]) r = IW'(i);
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < TMU_COUNT; i++) begin
            tex_in[i] = s_tex_colors[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        first_k        = lowest(stg_en);
        next_k         = lowest(pend);
        cfg_ok         = ({28'd0, cfg_tmu} < 32'(TMU_COUNT));
        cfg_idx        = cfg_tmu[IW-1:0];
        cfg_func_clean = (cfg_func > 3'd5) ? 3'd0 : cfg_func;
    end

    assign s_ready   = (state == IDLE) && !reset;
    assign m_valid   = (state == OUT);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // te_primary_color doubles as the running accumulator: each stage result is loaded
    // straight into it when the next stage issues.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state            <= IDLE;
            stg_en           <= '0;
            pend             <= '0;
            cur_k            <= '0;
            cnt              <= '0;
            te_func          <= '0;
            te_tex_src_color <= '0;
            te_primary_color <= '0;
            te_env_color     <= '0;
            m_color          <= '0;
            for (int i = 0; i < TMU_COUNT; i++) begin
                stg_func[i] <= '0;
                stg_env[i]  <= '0;
                wrk_func[i] <= '0;
                wrk_env[i]  <= '0;
                wrk_tex[i]  <= '0;
            end
        end else begin
            if (cfg_we && cfg_ok) begin
                stg_en[cfg_idx]   <= cfg_enable;
                stg_func[cfg_idx] <= cfg_func_clean;
                stg_env[cfg_idx]  <= cfg_env_color;
            end
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        pend <= stg_en;
                        for (int i = 0; i < TMU_COUNT; i++) begin
                            wrk_func[i] <= stg_func[i];
                            wrk_env[i]  <= stg_env[i];
                            wrk_tex[i]  <= tex_in[i];
                        end
                        if (stg_en == '0) begin
                            m_color <= s_primary_color;
                            state   <= OUT;
                        end else begin
                            cur_k            <= first_k;
                            te_func          <= stg_func[first_k];
                            te_tex_src_color <= tex_in[first_k];
                            te_primary_color <= s_primary_color;
                            te_env_color     <= stg_env[first_k];
                            state            <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    pend[cur_k] <= 1'b0;
                    cnt         <= CNT_INIT;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pend != '0) begin
                        cur_k            <= next_k;
                        te_func          <= wrk_func[next_k];
                        te_tex_src_color <= wrk_tex[next_k];
                        te_primary_color <= te_color;
                        te_env_color     <= wrk_env[next_k];
                        state            <= ISSUE;
                    end else begin
                        m_color <= te_color;
                        state   <= OUT;
                    end
                end
                default: begin
                    if (m_ready) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tex_env_sequencer.md
Name: tex_env_sequencer

Overview:
- Multi-texture scheduler that time-shares one TexEnv instance (2-cycle pipelined colour combiner) across TMU_COUNT texture stages for each fragment.
- Per-stage config (enable, func, env colour) is held in staging registers and snapshotted when a fragment is accepted.
- Enabled stages run in ascending order. Each stage's result becomes the next stage's primary colour (Cp), as in OpenGL multitexture chaining.
- Sits between the texture sampler output and the fragment/blend pipeline.

Parameters:
- SUB_PIXEL_WIDTH, 8, bits per colour channel; PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH (localparam).
- TMU_COUNT, 2, number of texture stages (1..16).
- TEXENV_LATENCY, 2, cycles from te_* inputs to valid te_color (min 1).

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  config write strobe
- cfg_tmu  in  4  target stage index
- cfg_enable  in  1  stage enable
- cfg_func  in  3  DISABLE=0 REPLACE=1 MODULATE=2 DECAL=3 BLEND=4 ADD=5
- cfg_env_color  in  PIXEL_WIDTH  stage env colour (Cc)
- s_valid  in  1  fragment valid
- s_ready  out  1  fragment accept
- s_primary_color  in  PIXEL_WIDTH  fragment colour (Cf)
- s_tex_colors  in  TMU_COUNT*PIXEL_WIDTH  stage i texel at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
- te_func  out  3  to TexEnv func
- te_tex_src_color  out  PIXEL_WIDTH  to TexEnv texSrcColor
- te_primary_color  out  PIXEL_WIDTH  to TexEnv primaryColor
- te_env_color  out  PIXEL_WIDTH  to TexEnv envColor
- te_color  in  PIXEL_WIDTH  from TexEnv color
- m_valid  out  1  result valid
- m_ready  in  1  downstream accept
- m_color  out  PIXEL_WIDTH  final colour
- busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous and active-high, effective at any time including mid-fragment:
  - state=IDLE; in-flight fragment dropped.
  - s_ready=0 during the reset cycle, then 1. m_valid=0, m_color=0, busy=0.
  - te_func=0, all te_* colours=0.
  - All staging config cleared: enable=0, func=0, env=0.
- Config write (cfg_we=1):
  - Writes the staging regs of cfg_tmu at any state.
  - cfg_tmu >= TMU_COUNT: write ignored.
  - cfg_func > 5: stored as 0 (DISABLE).
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: s_ready=1. On s_valid & s_ready:
  - Latch s_primary_color into accumulator ACC and latch s_tex_colors.
  - Snapshot all staging config into working regs. A cfg write in the same cycle is not included in the snapshot; it applies to the next fragment.
  - Select k = lowest enabled stage.
  - No stage enabled: go to OUT with m_color=ACC (bypass; m_valid high the cycle after acceptance).
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - te_func=func[k], te_tex_src_color=tex[k], te_primary_color=ACC, te_env_color=env[k].
  - Go to WAIT with counter=TEXENV_LATENCY-1; if that is 0, behave as the final WAIT cycle.
- WAIT:
  - te_* hold their ISSUE values.
  - Counter decrements each cycle. In the cycle counter reaches 0 (TEXENV_LATENCY cycles after ISSUE), te_color is captured into ACC on that clock edge.
  - Next enabled stage exists: k=next enabled, go to ISSUE.
  - Else: m_color=te_color, go to OUT.
- Disabled stages are skipped with zero cycle cost.
- OUT: m_valid=1, m_color stable until m_ready=1. On handshake: m_valid=0, go to IDLE.
- s_ready=0 in every state except IDLE. No overlap between fragments.
- Latency from acceptance edge to first m_valid cycle: 1 + E*(1+TEXENV_LATENCY), where E = number of enabled stages (E=0 gives 1).
- te_* hold their last driven values in IDLE and OUT.

Test Plan:
Bench uses a TexEnv stub: te_color = te_tex_src_color XOR te_primary_color, registered TEXENV_LATENCY=2 cycles.
- Reset then idle -> s_ready=1, m_valid=0, busy=0, te_func=0. No stages enabled; accept primary 0x10203040 -> m_valid next cycle, m_color=0x10203040.
- Stage0 enabled REPLACE, primary 0x0000FFFF, tex0 0xFF00FF00 -> te_func=1 in ISSUE cycle 1; m_valid in cycle 4; m_color=0xFF0000FF.
- Stages 0 and 1 enabled, tex0 0x01010101, tex1 0x10101010, primary 0 -> stage1 te_primary_color=0x01010101; m_valid in cycle 7; m_color=0x11111111.
- Stage1-only enable, TMU_COUNT=2 -> stage0 skipped, single ISSUE with te_tex_src_color=tex1; latency 4. cfg write tmu=5 -> no change. cfg_func=7 -> readback behaviour DISABLE (te_func=0).
- cfg write to stage0 in the same cycle as acceptance -> current fragment uses the old func; next fragment uses the new one. Hold m_ready=0 for 5 cycles -> m_valid and m_color stable, s_ready=0.
- Assert reset during WAIT -> next cycle: state IDLE, m_valid=0, stages disabled; a subsequent fragment takes the bypass path.
